// File: rtl/transmissao_pkg.sv
// Shared state codes, separator byte and width helper for the serial grid
// transmission control unit (separator feature: TX_SEPARADOR_LINHA_EN).
package transmissao_pkg;

    localparam logic [3:0] COD_INICIAL    = 4'b0000;
    localparam logic [3:0] COD_PREPARACAO = 4'b0001;
    localparam logic [3:0] COD_TRANSMITE  = 4'b0010;
    localparam logic [3:0] COD_ESPERA     = 4'b0011;
    localparam logic [3:0] COD_AVANCA     = 4'b0100;
    localparam logic [3:0] COD_SEPARADOR  = 4'b0101;
    localparam logic [3:0] COD_ESPERA_SEP = 4'b0110;
    localparam logic [3:0] COD_FIM        = 4'b1111;
    localparam logic [3:0] COD_INVALIDO   = 4'b1110;

    typedef enum logic [3:0] {
        INICIAL    = COD_INICIAL,
        PREPARACAO = COD_PREPARACAO,
        TRANSMITE  = COD_TRANSMITE,
        ESPERA     = COD_ESPERA,
        AVANCA     = COD_AVANCA,
        SEPARADOR  = COD_SEPARADOR,
        ESPERA_SEP = COD_ESPERA_SEP,
        FIM        = COD_FIM
    } estado_t;

    // Byte the datapath sends in place of cell data while sel_separador is high.
    localparam logic [7:0] BYTE_SEPARADOR = 8'h0A;

    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transmissao_matriz_serial_uc_contador.sv
// Modulo-MODULO counter with synchronous clear, count enable and terminal flag.
module contador_limite
    import transmissao_pkg::*;
#(
    parameter int MODULO = 3,
    localparam int W = largura(MODULO)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);

    localparam logic [W-1:0] MAXIMO = W'(MODULO - 1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (zera) begin
            q_d = '0;
        end else if (conta) begin
            q_d = (q_q == MAXIMO) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign fim = (q_q == MAXIMO);

endmodule

// File: rtl/transmissao_matriz_serial_uc.sv
// Control unit streaming a LINHAS x COLUNAS grid over the serial transmitter.
// Define TX_SEPARADOR_LINHA_EN to send a separator byte after every row.
module transmissao_matriz_serial_uc
    import transmissao_pkg::*;
#(
    parameter int LINHAS           = 3,
    parameter int COLUNAS          = 3,
    parameter int BYTES_POR_CELULA = 1,
    parameter int TIMEOUT_CICLOS   = 1000000
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  iniciar,
    input  logic                                  parar,
    input  logic                                  pronto,
    output logic                                  partida_serial,
    output logic [largura(LINHAS)-1:0]            linha,
    output logic [largura(COLUNAS)-1:0]           coluna,
    output logic [largura(BYTES_POR_CELULA)-1:0]  sel_byte,
    output logic                                  sel_separador,
    output logic                                  ocupado,
    output logic                                  fim,
    output logic                                  erro_timeout,
    output logic [3:0]                            db_estado
);

    localparam int TW = largura(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          erro_q, erro_d;
    logic          partida_q, partida_d;
    logic          fim_q, fim_d;
    logic          ocupado_q, ocupado_d;

    logic zera;
    logic conta_byte, conta_col, conta_lin;
    logic byte_fim, col_fim, lin_fim;
    logic estouro;

`ifdef TX_SEPARADOR_LINHA_EN
    logic ultima_linha_q, ultima_linha_d;
    logic sel_sep_q, sel_sep_d;
`endif

    contador_limite #(.MODULO(BYTES_POR_CELULA)) u_cont_byte (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta_byte),
        .q     (sel_byte),
        .fim   (byte_fim)
    );

    contador_limite #(.MODULO(COLUNAS)) u_cont_coluna (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta_col),
        .q     (coluna),
        .fim   (col_fim)
    );

    contador_limite #(.MODULO(LINHAS)) u_cont_linha (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta_lin),
        .q     (linha),
        .fim   (lin_fim)
    );

    assign estouro = (timer_q == TIMER_MAX);

    always_comb begin
        estado_d   = estado_q;
        timer_d    = timer_q;
        erro_d     = erro_q;
        zera       = 1'b0;
        conta_byte = 1'b0;
        conta_col  = 1'b0;
        conta_lin  = 1'b0;
`ifdef TX_SEPARADOR_LINHA_EN
        ultima_linha_d = ultima_linha_q;
`endif
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                zera     = 1'b1;
                erro_d   = 1'b0;
                estado_d = TRANSMITE;
            end
            TRANSMITE: begin
                timer_d  = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (pronto) begin
                    estado_d = AVANCA;
                end else if (estouro) begin
                    erro_d   = 1'b1;
                    estado_d = INICIAL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            AVANCA: begin
                // Byte, column and row form one ripple chain; the row stops at its last value.
                conta_byte = 1'b1;
                conta_col  = byte_fim;
                conta_lin  = byte_fim && col_fim && !lin_fim;
                if (!(byte_fim && col_fim)) begin
                    estado_d = TRANSMITE;
`ifdef TX_SEPARADOR_LINHA_EN
                end else begin
                    ultima_linha_d = lin_fim;
                    estado_d       = SEPARADOR;
                end
`else
                end else if (!lin_fim) begin
                    estado_d = TRANSMITE;
                end else begin
                    estado_d = FIM;
                end
`endif
            end
`ifdef TX_SEPARADOR_LINHA_EN
            SEPARADOR: begin
                timer_d  = '0;
                estado_d = ESPERA_SEP;
            end
            ESPERA_SEP: begin
                if (pronto) begin
                    estado_d = ultima_linha_q ? FIM : TRANSMITE;
                end else if (estouro) begin
                    erro_d   = 1'b1;
                    estado_d = INICIAL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            FIM: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Abort freezes all bookkeeping and only returns the FSM to idle.
        if (parar) begin
            estado_d   = INICIAL;
            timer_d    = timer_q;
            erro_d     = erro_q;
            zera       = 1'b0;
            conta_byte = 1'b0;
            conta_col  = 1'b0;
            conta_lin  = 1'b0;
`ifdef TX_SEPARADOR_LINHA_EN
            ultima_linha_d = ultima_linha_q;
`endif
        end
    end

    always_comb begin
        fim_d     = (estado_d == FIM);
        ocupado_d = (estado_d != INICIAL);
`ifdef TX_SEPARADOR_LINHA_EN
        partida_d = (estado_d == TRANSMITE) || (estado_d == SEPARADOR);
        sel_sep_d = (estado_d == SEPARADOR) || (estado_d == ESPERA_SEP);
`else
        partida_d = (estado_d == TRANSMITE);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            timer_q   <= '0;
            erro_q    <= 1'b0;
            partida_q <= 1'b0;
            fim_q     <= 1'b0;
            ocupado_q <= 1'b0;
`ifdef TX_SEPARADOR_LINHA_EN
            ultima_linha_q <= 1'b0;
            sel_sep_q      <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            erro_q    <= erro_d;
            partida_q <= partida_d;
            fim_q     <= fim_d;
            ocupado_q <= ocupado_d;
`ifdef TX_SEPARADOR_LINHA_EN
            ultima_linha_q <= ultima_linha_d;
            sel_sep_q      <= sel_sep_d;
`endif
        end
    end

    always_comb begin
        case (estado_q)
            INICIAL, PREPARACAO, TRANSMITE, ESPERA, AVANCA, FIM: db_estado = estado_q;
`ifdef TX_SEPARADOR_LINHA_EN
            SEPARADOR, ESPERA_SEP: db_estado = estado_q;
`endif
            default: db_estado = COD_INVALIDO;
        endcase
    end

    assign partida_serial = partida_q;
    assign fim            = fim_q;
    assign ocupado        = ocupado_q;
    assign erro_timeout   = erro_q;
`ifdef TX_SEPARADOR_LINHA_EN
    assign sel_separador  = sel_sep_q;
`else
    assign sel_separador  = 1'b0;
`endif

endmodule

// File: tb/tb_transmissao_matriz_serial_uc.sv
// Scoreboard bench for transmissao_matriz_serial_uc (3x3 grid, 2 bytes per cell);
// follows TX_SEPARADOR_LINHA_EN when it is defined.
module tb_transmissao_matriz_serial_uc;
    import transmissao_pkg::*;

    localparam int LINHAS  = 3;
    localparam int COLUNAS = 3;
    localparam int BYTES   = 2;
    localparam int TIMEOUT = 12;
    localparam int LW = largura(LINHAS);
    localparam int CW = largura(COLUNAS);
    localparam int BW = largura(BYTES);
`ifdef TX_SEPARADOR_LINHA_EN
    localparam bit COM_SEP = 1'b1;
`else
    localparam bit COM_SEP = 1'b0;
`endif

    typedef struct {
        bit sep;
        int lin;
        int col;
        int byt;
    } entrada_t;

    logic          clock, reset, iniciar, parar, pronto;
    logic          partida_serial, sel_separador, ocupado, fim, erro_timeout;
    logic [LW-1:0] linha;
    logic [CW-1:0] coluna;
    logic [BW-1:0] sel_byte;
    logic [3:0]    db_estado;

    entrada_t esperado_q[$];
    entrada_t quadro[$];

    int ciclo = 0;
    int total = 0;
    int passou = 0;
    int fims_esperados = 0;
    int fims_vistos = 0;
    int quadros_iniciados = 0;
    int quadros_vistos = 0;
    int ciclo_iniciar = 0;
    int n_partidas_vistas = 0;
    int ultima_partida_ciclo = 0;
    int partidas_resp = 0;
    int limite_respostas = 1 << 30;
    int ultimo_pronto_ciclo = 0;
    bit modo_hold = 1'b0;
    bit checar_latencia_fim = 1'b1;

    transmissao_matriz_serial_uc #(
        .LINHAS(LINHAS), .COLUNAS(COLUNAS),
        .BYTES_POR_CELULA(BYTES), .TIMEOUT_CICLOS(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar), .pronto(pronto),
        .partida_serial(partida_serial), .linha(linha), .coluna(coluna),
        .sel_byte(sel_byte), .sel_separador(sel_separador), .ocupado(ocupado),
        .fim(fim), .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) ciclo <= ciclo + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string nome, input int atual, input int esperado);
        total++;
        if (atual == esperado) passou++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    endtask

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    // Reference frame: row-major cells, bytes inside each cell, optional separator per row.
    task automatic geraQuadro();
        entrada_t e;
        quadro.delete();
        for (int l = 0; l < LINHAS; l++) begin
            for (int c = 0; c < COLUNAS; c++) begin
                for (int b = 0; b < BYTES; b++) begin
                    e.sep = 1'b0; e.lin = l; e.col = c; e.byt = b;
                    quadro.push_back(e);
                end
            end
            if (COM_SEP) begin
                e.sep = 1'b1; e.lin = 0; e.col = 0; e.byt = 0;
                quadro.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input int n_itens, input bit completa);
        geraQuadro();
        for (int i = 0; i < n_itens; i++) esperado_q.push_back(quadro[i]);
        if (completa) fims_esperados++;
        ciclo_iniciar = ciclo;
        quadros_iniciados++;
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
    endtask

    task automatic aguardaFim(input int limite);
        int n = 0;
        while (fims_vistos < fims_esperados && n < limite) begin
            passo();
            n++;
        end
        checkOutput("frame finished in time", fims_vistos, fims_esperados);
    endtask

    task automatic aguardaPartidas(input int alvo, input int limite);
        int n = 0;
        while (n_partidas_vistas < alvo && n < limite) begin
            passo();
            n++;
        end
        checkOutput("partida count reached", n_partidas_vistas, alvo);
    endtask

    task automatic checaZerado(input string tag);
        checkOutput({tag, " partida"}, int'(partida_serial), 0);
        checkOutput({tag, " linha"}, int'(linha), 0);
        checkOutput({tag, " coluna"}, int'(coluna), 0);
        checkOutput({tag, " sel_byte"}, int'(sel_byte), 0);
        checkOutput({tag, " sel_separador"}, int'(sel_separador), 0);
        checkOutput({tag, " ocupado"}, int'(ocupado), 0);
        checkOutput({tag, " fim"}, int'(fim), 0);
        checkOutput({tag, " erro_timeout"}, int'(erro_timeout), 0);
        checkOutput({tag, " db_estado"}, int'(db_estado), 0);
    endtask

    // Transmitter model: answers each start pulse after 1..5 cycles, or holds pronto high.
    initial begin : responder
        int espera;
        espera = 0;
        pronto = 1'b0;
        forever begin
            passo();
            if (modo_hold) begin
                pronto = 1'b1;
                espera = 0;
            end else begin
                pronto = 1'b0;
                if (espera > 0) begin
                    espera--;
                    if (espera == 0) begin
                        pronto = 1'b1;
                        ultimo_pronto_ciclo = ciclo;
                    end
                end
            end
            if (partida_serial) begin
                if (partidas_resp < limite_respostas && !modo_hold)
                    espera = $urandom_range(5, 1);
                partidas_resp++;
            end
        end
    end

    // Monitor: pops the scoreboard on every start pulse and audits every fim pulse.
    initial begin : monitor
        entrada_t e;
        forever begin
            @(negedge clock);
            if (partida_serial) begin
                n_partidas_vistas++;
                ultima_partida_ciclo = ciclo;
                if (quadros_vistos < quadros_iniciados) begin
                    checkOutput("first partida latency", ciclo - ciclo_iniciar, 2);
                    quadros_vistos = quadros_iniciados;
                end
                checkOutput("partida was expected", int'(esperado_q.size() > 0), 1);
                if (esperado_q.size() > 0) begin
                    e = esperado_q.pop_front();
                    checkOutput($sformatf("sel_separador tx%0d", n_partidas_vistas),
                                int'(sel_separador), int'(e.sep));
                    if (!e.sep)
                        checkOutput($sformatf("lin*10000+col*100+byte tx%0d", n_partidas_vistas),
                                    int'(linha) * 10000 + int'(coluna) * 100 + int'(sel_byte),
                                    e.lin * 10000 + e.col * 100 + e.byt);
                end
            end
            if (fim) begin
                fims_vistos++;
                checkOutput("fim was expected", int'(fims_vistos <= fims_esperados), 1);
                checkOutput("scoreboard empty at fim", esperado_q.size(), 0);
                checkOutput("ocupado during fim", int'(ocupado), 1);
                if (checar_latencia_fim)
                    checkOutput("fim latency after last pronto", ciclo - ultimo_pronto_ciclo, 2);
            end
        end
    end

    initial begin : estimulo
        int base;
        int k;
        iniciar = 1'b0;
        parar   = 1'b0;
        reset   = 1'b1;
        repeat (3) passo();
        checaZerado("reset");
        reset = 1'b0;
        passo();

        // Normal frames with random pronto delays.
        for (int f = 0; f < 4; f++) begin
            base = n_partidas_vistas;
            geraQuadro();
            applyStimulus(quadro.size(), 1'b1);
            aguardaFim(2000);
            checkOutput("ocupado low after fim", int'(ocupado), 0);
            checkOutput("fim is one cycle", int'(fim), 0);
            checkOutput("pulses per frame", n_partidas_vistas - base,
                        LINHAS * COLUNAS * BYTES + (COM_SEP ? LINHAS : 0));
            checkOutput("final linha", int'(linha), LINHAS - 1);
            checkOutput("final coluna", int'(coluna), 0);
            checkOutput("final sel_byte", int'(sel_byte), 0);
            repeat ($urandom_range(4, 1)) passo();
        end

        // Timeout: the 5th pulse is never answered.
        limite_respostas = partidas_resp + 4;
        base = n_partidas_vistas;
        applyStimulus(5, 1'b0);
        aguardaPartidas(base + 5, 500);
        k = 0;
        while (!erro_timeout && k < 100) begin
            passo();
            k++;
        end
        checkOutput("erro_timeout set", int'(erro_timeout), 1);
        checkOutput("timeout latency", ciclo - ultima_partida_ciclo, TIMEOUT + 1);
        checkOutput("idle after timeout", int'(ocupado), 0);
        checkOutput("db_estado after timeout", int'(db_estado), 0);
        repeat (5) passo();
        checkOutput("erro_timeout sticky", int'(erro_timeout), 1);
        limite_respostas = 1 << 30;
        geraQuadro();
        applyStimulus(quadro.size(), 1'b1);
        passo();
        checkOutput("erro_timeout cleared by new frame", int'(erro_timeout), 0);
        aguardaFim(2000);
        repeat (3) passo();

        // Abort while waiting for pronto of cell (1, last column, byte 0).
        geraQuadro();
        k = 0;
        for (int i = 0; i < quadro.size(); i++)
            if (!quadro[i].sep && quadro[i].lin == 1 && quadro[i].col == COLUNAS - 1 &&
                quadro[i].byt == 0 && k == 0) k = i;
        limite_respostas = partidas_resp + k;
        base = n_partidas_vistas;
        applyStimulus(k + 1, 1'b0);
        aguardaPartidas(base + k + 1, 500);
        repeat (2) passo();
        parar = 1'b1;
        passo();
        parar = 1'b0;
        checkOutput("abort ocupado", int'(ocupado), 0);
        checkOutput("abort db_estado", int'(db_estado), 0);
        checkOutput("abort linha held", int'(linha), 1);
        checkOutput("abort coluna held", int'(coluna), COLUNAS - 1);
        checkOutput("abort erro_timeout unchanged", int'(erro_timeout), 0);
        base = n_partidas_vistas;
        modo_hold = 1'b1;
        repeat (10) passo();
        modo_hold = 1'b0;
        checkOutput("pronto after abort gives no partida", n_partidas_vistas - base, 0);
        limite_respostas = 1 << 30;

        // iniciar together with parar stays idle.
        iniciar = 1'b1;
        parar   = 1'b1;
        passo();
        iniciar = 1'b0;
        parar   = 1'b0;
        checkOutput("iniciar+parar stays idle", int'(ocupado), 0);
        repeat (5) passo();

        // pronto held high for the whole frame, plus a stray iniciar mid-frame.
        modo_hold = 1'b1;
        checar_latencia_fim = 1'b0;
        base = n_partidas_vistas;
        geraQuadro();
        applyStimulus(quadro.size(), 1'b1);
        repeat (7) passo();
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        aguardaFim(2000);
        checkOutput("hold frame pulse count", n_partidas_vistas - base, quadro.size());
        modo_hold = 1'b0;
        checar_latencia_fim = 1'b1;
        repeat (10) passo();

        // Synchronous reset in the middle of a frame.
        base = n_partidas_vistas;
        geraQuadro();
        applyStimulus(quadro.size(), 1'b0);
        aguardaPartidas(base + 3, 500);
        passo();
        reset = 1'b1;
        passo();
        checaZerado("mid-frame reset");
        reset = 1'b0;
        esperado_q.delete();
        repeat (10) passo();

        // Recovery frame after the reset.
        geraQuadro();
        applyStimulus(quadro.size(), 1'b1);
        aguardaFim(2000);
        repeat (5) passo();

        checkOutput("scoreboard drained", esperado_q.size(), 0);
        checkOutput("total fim pulses", fims_vistos, fims_esperados);
        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule
